// File: rtl/oc8051_cxrom_fetch_pkg.sv
// Shared constants for the oc8051 code-ROM fetch unit.
//   FETCH_DEPTH : default byte-queue capacity
//   ROM_W       : width of one combinational ROM word (bits)
//   ROM_BYTES   : bytes delivered per ROM access
//   MAX_INSN    : longest oc8051 instruction in bytes (decoder window)
//   ADDR_W      : code address width
package oc8051_fetch_pkg;
  localparam int FETCH_DEPTH = 8;
  localparam int ROM_W       = 32;
  localparam int ROM_BYTES   = ROM_W / 8;
  localparam int MAX_INSN    = 3;
  localparam int ADDR_W      = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [7:0]        byte_t;
endpackage

// File: rtl/oc8051_cxrom_fetch_if.sv
// Bus bundle between the fetch unit and its neighbours (code ROM + decoder).
//   master : the fetch unit (drives cxrom_addr and the op_* window, count)
//   slave  : the core/ROM side (drives pc_load/pc_new, consume, cxrom_data_in)
interface oc8051_cxrom_fetch_if #(
  parameter int CNT_W = 4
);
  import oc8051_fetch_pkg::*;

  logic                    pc_load;
  addr_t                   pc_new;
  addr_t                   cxrom_addr;
  logic [ROM_W-1:0]        cxrom_data_in;
  logic                    op_valid;
  logic [MAX_INSN*8-1:0]   op_bytes;
  addr_t                   op_pc;
  logic [1:0]              consume;
  logic [CNT_W-1:0]        count;

  modport master (
    input  pc_load, pc_new, cxrom_data_in, consume,
    output cxrom_addr, op_valid, op_bytes, op_pc, count
  );

  modport slave (
    output pc_load, pc_new, cxrom_data_in, consume,
    input  cxrom_addr, op_valid, op_bytes, op_pc, count
  );
endinterface

// File: rtl/oc8051_cxrom_fetch_queue.sv
// Byte FIFO for the fetch unit.
//   push/push_data : append ROM_BYTES bytes, byte 0 first
//   pop_n          : drop 0..3 bytes from the head
//   flush          : synchronous empty; overrides push and pop
//   peek           : the MAX_INSN oldest bytes, byte 0 in the low lane
//   count          : occupancy in bytes
// DEPTH must be a power of two so the pointers wrap for free.
module oc8051_fetch_queue
  import oc8051_fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [ROM_W-1:0]      push_data,
  input  logic [1:0]            pop_n,
  output logic [MAX_INSN*8-1:0] peek,
  output logic [CNT_W-1:0]      count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][7:0] mem;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      cnt;

  // Peek lanes read straight from storage; wrap comes from the pointer width.
  for (genvar i = 0; i < MAX_INSN; i++) begin : g_peek
    assign peek[8*i +: 8] = mem[rd_ptr + PTR_W'(i)];
  end

  assign count = cnt;

  // Storage: writes may land on slots being popped this same edge; those
  // slots are free afterwards, and the peek above reads pre-edge contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (!flush && push) begin
      for (int i = 0; i < ROM_BYTES; i++)
        mem[wr_ptr + PTR_W'(i)] <= push_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_n);
      if (push) wr_ptr <= wr_ptr + PTR_W'(ROM_BYTES);
      cnt <= cnt - CNT_W'(pop_n) + (push ? CNT_W'(ROM_BYTES) : CNT_W'(0));
    end
  end

  // Occupancy must stay within [0, DEPTH]; anything else is a control bug upstream.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (int'(cnt) >= int'(pop_n));
      assert (int'(cnt) - int'(pop_n) + (push ? ROM_BYTES : 0) <= DEPTH);
    end
  end
endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// oc8051 code-ROM fetch unit: requester side of the combinational cxrom port.
//   clk, rst      : clock, asynchronous active-high reset
//   bus.master    : cxrom_addr/cxrom_data_in to the ROM, op_valid/op_bytes/op_pc
//                   window and consume from the decoder, pc_load/pc_new redirect,
//                   count (queue occupancy)
// The ROM answers in the same cycle, so a fill is a single-edge event: whenever
// the queue will have room for a whole word after this cycle's consume, the
// word at fetch_ptr is appended.  DEPTH: power of two, at least 8.
module oc8051_cxrom_fetch
  import oc8051_fetch_pkg::*;
#(
  parameter int    DEPTH    = FETCH_DEPTH,
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  oc8051_cxrom_fetch_if.master bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  addr_t              fetch_ptr, rd_pc;
  logic [CNT_W-1:0]   cnt, cnt_after;
  logic [1:0]         eff_c;
  logic               fill_en;
  logic               op_valid;

  assign op_valid = (cnt >= CNT_W'(MAX_INSN));

  // A consume against an incomplete window is meaningless and dropped.
  assign eff_c     = op_valid ? bus.consume : 2'd0;
  assign cnt_after = cnt - CNT_W'(eff_c);
  assign fill_en   = (cnt_after <= CNT_W'(DEPTH - ROM_BYTES));

  oc8051_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.pc_load),
    .push      (fill_en),
    .push_data (bus.cxrom_data_in),
    .pop_n     (eff_c),
    .peek      (bus.op_bytes),
    .count     (cnt)
  );

  // Redirect wins over both fill and consume of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_ptr <= RESET_PC;
      rd_pc     <= RESET_PC;
    end else if (bus.pc_load) begin
      fetch_ptr <= bus.pc_new;
      rd_pc     <= bus.pc_new;
    end else begin
      if (fill_en) fetch_ptr <= fetch_ptr + ADDR_W'(ROM_BYTES);
      rd_pc <= rd_pc + ADDR_W'(eff_c);
    end
  end

  assign bus.cxrom_addr = fetch_ptr;
  assign bus.op_valid   = op_valid;
  assign bus.op_pc      = rd_pc;
  assign bus.count      = cnt;
endmodule
